serial_subtractor: RTL
======================

# serial_subtractor

- Bit-serial two's-complement subtractor: computes a − b one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- Inverse of the team's ripple full-adder path.
- Sits between the switch-input operand registers and the LED result display.
- Used where operand width must scale without growing combinational ripple depth.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; sampled with start
- b  input  WIDTH  subtrahend; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  a − b mod 2^WIDTH; held until next completion
- borrow  output  1  1 when unsigned a < b; held with diff
- overflow  output  1  signed overflow; only present with SUB_OVERFLOW_EN

## Operation
- Reset value of every output: 0. State after reset: IDLE. Internal registers after reset: 0.
- States:
  - IDLE: start=1 latches a into shift register A and b into shift register B. It also clears the borrow flop and the bit counter. Next state RUN.
  - RUN: each cycle, the cell takes ai=A[0], bi=B[0], bin=borrow flop.
    - d = ai^bi^bin
    - bout = (~ai&bi) | (~(ai^bi)&bin)
    - d shifts into the MSB of internal result register R; R, A and B shift right by one.
    - borrow flop ← bout; counter increments.
    - When counter reaches WIDTH−1 on this edge, next state DONE. On that same edge, diff ← final R value (with d), borrow ← bout, and overflow is updated.
  - DONE: done=1 for exactly one cycle; next state IDLE.
- start while in RUN or DONE: ignored. It is not queued; the requester must re-assert it in IDLE.
- diff, borrow and overflow change only on the final RUN edge, so they stay stable while busy.
- Counter width: clog2(WIDTH). It never wraps mid-operation.
- Async reset mid-operation: abort immediately, all outputs and state cleared, no done pulse.

## Timing
- Edge E0 samples start in IDLE → busy=1 after E0.
- Edges E1..E_WIDTH process bits 0..WIDTH−1.
- After E_WIDTH: busy=0, done=1, and diff/borrow are valid.
- After E_WIDTH+1: done=0 and state is IDLE. A new start can be sampled at E_WIDTH+2 or later.
- Latency from the start-sampling edge to done: WIDTH cycles.
- Throughput: one operation per WIDTH+2 cycles.
- No combinational path from inputs to outputs.

## Configuration
- SUB_OVERFLOW_EN defined:
  - overflow port exists.
  - At the final edge: overflow ← (a_msb ≠ b_msb) & (diff_msb ≠ a_msb), using the latched operand MSBs.
  - Reset 0; held with diff.
- SUB_OVERFLOW_EN undefined: no overflow port and no MSB-capture registers. All other behaviour is identical.

## Structure
- Shared package: state encoding enum (IDLE, RUN, DONE) and the default WIDTH constant.
- Sub-module full_subtractor: purely combinational cell with inputs a, b, bin and outputs d, bout. Instantiated once.
- Top level holds the FSM, shift registers, counter and output registers.

## Test plan
- WIDTH=4, reset then a=7, b=3, start → done 4 cycles after the sampling edge; diff=4, borrow=0, overflow=0.
- a=3, b=7 → diff=0xC, borrow=1, overflow=0.
- a=0, b=0xF → diff=1, borrow=1, overflow=0. a=8, b=1 → diff=7, borrow=0, overflow=1 (macro defined).
- start held high continuously from IDLE with changing a/b → only the first sampled operands are used. Subsequent operations begin only on the start sampled in IDLE, i.e. every 6 cycles. diff stays stable while busy.
- rst_n low for 1 cycle during the 2nd RUN cycle → busy, done, diff and borrow go to 0 immediately; no done pulse. A fresh start then completes normally.
- Sweep all 256 (a, b) pairs against a reference model: diff, borrow and overflow match; done width is exactly 1 cycle.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b, LSB first, one bit per clock).
// Define SUB_OVERFLOW_EN to add the signed overflow output.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t         state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             bflop;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;

`ifdef SUB_OVERFLOW_EN
    logic a_msb;
    logic b_msb;
`endif

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bflop),
        .d    (d),
        .bout (bout)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // the cell outputs d/bout are read as this cycle's values, not next cycle's.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            bflop  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        r_sr  <= '0;
                        bflop <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SUB_OVERFLOW_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end

                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= {d, r_sr[WIDTH-1:1]};
                    bflop <= bout;
                    if (cnt == LAST) begin
                        // Final bit: publish the result; outputs only move on this edge.
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        diff   <= {d, r_sr[WIDTH-1:1]};
                        borrow <= bout;
`ifdef SUB_OVERFLOW_EN
                        overflow <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
